// File: rtl/core_lsu_if.sv
// Memory port bundle for the load/store unit: single-outstanding req/gnt/rvalid.
// Master (LSU) drives req/we/addr/wdata; slave (memory) drives gnt/rvalid/rdata.
interface core_lsu_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/core_lsu.sv
// Load/store unit: accepts one decoder request, runs it on the memory port,
// writes load data back to the ARF and pulses done_o to release the stall.
// Ports: clk_i/rst_i, lsu_* request, busy_o/done_o, arf_* writeback, mem port.
module core_lsu #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lsu_en_i,
    input  logic              lsu_wen_i,
    input  logic              lsu_kind_i,
    input  logic [3:0]        rd_i,
    input  logic [ADDR_W-1:0] addr_imm_i,
    input  logic [DATA_W-1:0] rt_val_i,
    input  logic [DATA_W-1:0] rd_val_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              arf_wen_o,
    output logic [3:0]        arf_waddr_o,
    output logic [DATA_W-1:0] arf_wdata_o,
    core_lsu_if.master        mem
);
    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        WB,
        DONE
    } state_t;

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              arf_wen_q;
    logic [3:0]        arf_waddr_q;
    logic [DATA_W-1:0] arf_wdata_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        rd_q;
    logic [ADDR_W-1:0] addr_d;

    // Indirect addresses simply drop the upper bits of R[t].
    assign addr_d = lsu_kind_i ? addr_imm_i : rt_val_i[ADDR_W-1:0];

    logic unused_rt_hi;
    assign unused_rt_hi = ^rt_val_i[DATA_W-1:ADDR_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            arf_wen_q   <= 1'b0;
            arf_waddr_q <= '0;
            arf_wdata_q <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (lsu_en_i) begin
                        state_q <= REQ;
                        busy_q  <= 1'b1;
                        req_q   <= 1'b1;
                        we_q    <= lsu_wen_i;
                        addr_q  <= addr_d;
                        wdata_q <= rd_val_i;
                        rd_q    <= rd_i;
                    end
                end
                REQ: begin
                    // Address/data stay put until the grant.
                    if (mem.mem_gnt) begin
                        req_q <= 1'b0;
                        if (we_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem.mem_rvalid) begin
                        state_q     <= WB;
                        done_q      <= 1'b1;
                        arf_wen_q   <= (rd_q != 4'd0);
                        arf_waddr_q <= rd_q;
                        arf_wdata_q <= mem.mem_rdata;
                    end
                end
                WB, DONE: begin
                    // busy stays high through the done cycle.
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    arf_wen_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign arf_wen_o     = arf_wen_q;
    assign arf_waddr_o   = arf_waddr_q;
    assign arf_wdata_o   = arf_wdata_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_core_lsu.sv
// Testbench for core_lsu: vector table driven through a request/memory model,
// with a scoreboard queue of expected writebacks and a few reset/protocol cases.
module tb_core_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_en = 1'b0;
    logic        lsu_wen = 1'b0;
    logic        lsu_kind = 1'b0;
    logic [3:0]  lsu_rd = '0;
    logic [7:0]  imm = '0;
    logic [15:0] rt_val = '0;
    logic [15:0] rd_val = '0;
    logic        busy_o;
    logic        done_o;
    logic        arf_wen_o;
    logic [3:0]  arf_waddr_o;
    logic [15:0] arf_wdata_o;

    int n_tot = 0;
    int n_pass = 0;
    int viol = 0;
    int exp_viol = 0;

    core_lsu_if #(.ADDR_W(8), .DATA_W(16)) mif();

    core_lsu #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .lsu_en_i    (lsu_en),
        .lsu_wen_i   (lsu_wen),
        .lsu_kind_i  (lsu_kind),
        .rd_i        (lsu_rd),
        .addr_imm_i  (imm),
        .rt_val_i    (rt_val),
        .rd_val_i    (rd_val),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .arf_wen_o   (arf_wen_o),
        .arf_waddr_o (arf_waddr_o),
        .arf_wdata_o (arf_wdata_o),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    // Protocol monitor: a request presented while busy is a violation.
    always @(posedge clk) begin
        if (!rst && lsu_en && busy_o) viol++;
    end

    typedef struct {
        logic        wen;
        logic        kind;
        logic [3:0]  rd;
        logic [7:0]  imm;
        logic [15:0] rt;
        logic [15:0] rdv;
        int          gd;
        int          rvd;
        logic [15:0] rdata;
        logic        spur;
        logic        intr;
        logic [7:0]  eaddr;
        logic        ewen;
        logic [15:0] ewdata;
    } vec_t;

    vec_t vecs[7];
    vec_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle_mem();
        mif.mem_gnt = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata = '0;
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic run_vec(input vec_t v);
        int gcyc;
        int lat;
        bit fin;
        vec_t e;
        lat = v.wen ? v.gd + 2 : v.gd + v.rvd + 3;
        sb_q.push_back(v);
        if (v.intr) exp_viol++;
        lsu_en = 1'b1;
        lsu_wen = v.wen;
        lsu_kind = v.kind;
        lsu_rd = v.rd;
        imm = v.imm;
        rt_val = v.rt;
        rd_val = v.rdv;
        gcyc = -1;
        fin = 1'b0;
        for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
            @(negedge clk);
            lsu_en = 1'b0;
            idle_mem();
            chk("busy_run", busy_o, 1);
            if (done_o) begin
                e = sb_q.pop_front();
                chk("latency", cyc, lat);
                chk("arf_wen", arf_wen_o, e.ewen);
                if (e.ewen) begin
                    chk("arf_waddr", arf_waddr_o, e.rd);
                    chk("arf_wdata", arf_wdata_o, e.ewdata);
                end
                fin = 1'b1;
            end else begin
                chk("arf_wen_early", arf_wen_o, 0);
            end
            if (!fin && gcyc < 0) begin
                chk("req", mif.mem_req, 1);
                chk("we", mif.mem_we, v.wen);
                chk("addr", mif.mem_addr, v.eaddr);
                if (v.wen) chk("wdata", mif.mem_wdata, v.rdv);
                if (cyc - 1 == v.gd) begin
                    mif.mem_gnt = 1'b1;
                    gcyc = cyc;
                end else if (v.spur) begin
                    mif.mem_rvalid = 1'b1;
                    mif.mem_rdata = 16'hDEAD;
                end
                if (v.intr && cyc == 1) begin
                    lsu_en = 1'b1;
                    lsu_wen = ~v.wen;
                    lsu_kind = 1'b1;
                    lsu_rd = ~v.rd;
                    imm = ~v.imm;
                    rd_val = 16'h5555;
                end
            end else if (!fin) begin
                chk("req_drop", mif.mem_req, 0);
                if (!v.wen && cyc - gcyc - 1 == v.rvd) begin
                    mif.mem_rvalid = 1'b1;
                    mif.mem_rdata = v.rdata;
                end
            end
        end
        if (!fin) begin
            chk("timeout", 0, 1);
            sb_q.delete();
        end
        @(negedge clk);
        chk("busy_after", busy_o, 0);
        chk("done_after", done_o, 0);
        chk("arf_wen_after", arf_wen_o, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_arf_wen"}, arf_wen_o, 0);
        chk({tag, "_arf_waddr"}, arf_waddr_o, 0);
        chk({tag, "_arf_wdata"}, arf_wdata_o, 0);
        chk({tag, "_req"}, mif.mem_req, 0);
        chk({tag, "_we"}, mif.mem_we, 0);
        chk({tag, "_addr"}, mif.mem_addr, 0);
        chk({tag, "_wdata"}, mif.mem_wdata, 0);
    endtask

    initial begin
        //           wen   kind  rd     imm     rt        rdv       gd rvd rdata     spur  intr  eaddr   ewen  ewdata
        vecs[0] = '{1'b0, 1'b1, 4'd3, 8'h42, 16'h0000, 16'h0000, 0, 0, 16'hBEEF, 1'b0, 1'b0, 8'h42, 1'b1, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b0, 4'd5, 8'h00, 16'h1234, 16'h00AA, 4, 0, 16'h0000, 1'b0, 1'b0, 8'h34, 1'b0, 16'h0000};
        vecs[2] = '{1'b0, 1'b1, 4'd0, 8'h10, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 1'b0, 1'b0, 8'h10, 1'b0, 16'h0000};
        vecs[3] = '{1'b0, 1'b0, 4'd7, 8'h00, 16'h5A81, 16'h0000, 2, 6, 16'hC0DE, 1'b1, 1'b0, 8'h81, 1'b1, 16'hC0DE};
        vecs[4] = '{1'b1, 1'b1, 4'd2, 8'hFF, 16'h0000, 16'h1357, 0, 0, 16'h0000, 1'b0, 1'b0, 8'hFF, 1'b0, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 4'd9, 8'h20, 16'h0000, 16'h0000, 3, 1, 16'h4321, 1'b0, 1'b1, 8'h20, 1'b1, 16'h4321};
        vecs[6] = '{1'b0, 1'b0, 4'd1, 8'h77, 16'hABCD, 16'h0000, 1, 2, 16'h0F0F, 1'b0, 1'b0, 8'hCD, 1'b1, 16'h0F0F};

        idle_mem();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);
        chk("proto_viol", viol, exp_viol);
        chk("sb_empty", sb_q.size(), 0);

        // Reset while waiting for read data, then a late rvalid.
        lsu_en = 1'b1;
        lsu_wen = 1'b0;
        lsu_kind = 1'b1;
        lsu_rd = 4'd6;
        imm = 8'h55;
        @(negedge clk);
        lsu_en = 1'b0;
        chk("rst_seq_req", mif.mem_req, 1);
        mif.mem_gnt = 1'b1;
        @(negedge clk);
        idle_mem();
        chk("rst_seq_wait_busy", busy_o, 1);
        chk("rst_seq_wait_req", mif.mem_req, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mif.mem_rvalid = 1'b1;
        mif.mem_rdata = 16'h9999;
        chk_zero("midrst");
        @(negedge clk);
        idle_mem();
        chk("late_rv_done", done_o, 0);
        chk("late_rv_arf_wen", arf_wen_o, 0);
        chk("late_rv_busy", busy_o, 0);
        chk("late_rv_wdata", arf_wdata_o, 0);
        @(negedge clk);
        run_vec(vecs[0]);
        run_vec(vecs[4]);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
